// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store bus bridge.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] BE_B = 4'b0001;
  localparam logic [3:0] BE_H = 4'b0011;
  localparam logic [3:0] BE_W = 4'b1111;

  // funct3[1:0] encodes the access size for both loads and stores.
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;

endpackage

// File: rtl/lsu_align.sv
// Lane steering: store byte enables / replication and load lane select / extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_wdata,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata_rep,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_off,
  input  logic [31:0] ld_word,
  output logic [31:0] ld_ext
);

  logic [31:0] ld_shift;

  always_comb begin
    st_be = BE_W;
    case (st_size)
      SZ_B:    st_be = BE_B << st_off;
      SZ_H:    st_be = BE_H << st_off;
      default: st_be = BE_W;
    endcase
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign st_wdata_rep[gi*8 +: 8] =
      (st_size == SZ_B) ? st_wdata[7:0] :
      (st_size == SZ_H) ? st_wdata[(gi % 2)*8 +: 8] :
                          st_wdata[gi*8 +: 8];
  end

  assign ld_shift = ld_word >> {ld_off, 3'b000};

  always_comb begin
    ld_ext = ld_word;
    case (ld_funct3)
      F3_B:    ld_ext = {{24{ld_shift[7]}}, ld_shift[7:0]};
      F3_H:    ld_ext = {{16{ld_shift[15]}}, ld_shift[15:0]};
      F3_BU:   ld_ext = {24'd0, ld_shift[7:0]};
      F3_HU:   ld_ext = {16'd0, ld_shift[15:0]};
      default: ld_ext = ld_word;
    endcase
  end

endmodule

// File: rtl/lsu_bus_bridge.sv
// Load/store unit: turns core MemRead/MemWrite into a req/ack bus access, stalling the core.
module lsu_bus_bridge
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        fault,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic        bus_err,
  input  logic [31:0] bus_rdata
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  lsu_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       bus_addr_q, bus_addr_d;
  logic              bus_we_q, bus_we_d;
  logic [3:0]        bus_be_q, bus_be_d;
  logic [31:0]       bus_wdata_q, bus_wdata_d;
  logic [2:0]        f3_q, f3_d;
  logic [1:0]        off_q, off_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              done_fault_q, done_fault_d;

  logic              is_load, is_store, f3_ok, aligned, req_ok;
  logic              stall_c, fault_c;
  logic [3:0]        st_be;
  logic [31:0]       st_wdata_rep, ld_ext;

  lsu_align u_align (
    .st_size      (funct3[1:0]),
    .st_off       (addr[1:0]),
    .st_wdata     (wdata),
    .st_be        (st_be),
    .st_wdata_rep (st_wdata_rep),
    .ld_funct3    (f3_q),
    .ld_off       (off_q),
    .ld_word      (bus_rdata),
    .ld_ext       (ld_ext)
  );

  // Asserting both request lines is treated as an illegal request.
  assign is_load  = mem_read & ~mem_write;
  assign is_store = mem_write & ~mem_read;

  always_comb begin
    f3_ok = 1'b0;
    if (is_load)
      f3_ok = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
              (funct3 == F3_BU) || (funct3 == F3_HU);
    else if (is_store)
      f3_ok = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
  end

  assign aligned = (funct3[1:0] == SZ_B) ||
                   ((funct3[1:0] == SZ_H) && (addr[0] == 1'b0)) ||
                   (addr[1:0] == 2'b00);
  assign req_ok  = f3_ok & aligned;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bus_addr_d   = bus_addr_q;
    bus_we_d     = bus_we_q;
    bus_be_d     = bus_be_q;
    bus_wdata_d  = bus_wdata_q;
    f3_d         = f3_q;
    off_d        = off_q;
    rdata_d      = rdata_q;
    done_fault_d = 1'b0;
    stall_c      = 1'b0;
    fault_c      = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_read || mem_write) begin
          if (req_ok) begin
            stall_c     = 1'b1;
            state_d     = REQ;
            cnt_d       = '0;
            bus_addr_d  = {addr[31:2], 2'b00};
            bus_we_d    = is_store;
            bus_be_d    = st_be;
            bus_wdata_d = st_wdata_rep;
            f3_d        = funct3;
            off_d       = addr[1:0];
          end else begin
            fault_c = 1'b1;
          end
        end
      end
      REQ: begin
        stall_c = 1'b1;
        cnt_d   = cnt_q + CNT_ONE;
        // An ack in the final allowed cycle wins over the timeout.
        if (bus_ack) begin
          state_d = DONE;
          if (bus_err)
            done_fault_d = 1'b1;
          else if (!bus_we_q)
            rdata_d = ld_ext;
        end else if (cnt_q == CNT_LAST) begin
          state_d      = DONE;
          done_fault_d = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      bus_addr_q   <= '0;
      bus_we_q     <= 1'b0;
      bus_be_q     <= '0;
      bus_wdata_q  <= '0;
      f3_q         <= '0;
      off_q        <= '0;
      rdata_q      <= '0;
      done_fault_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bus_addr_q   <= bus_addr_d;
      bus_we_q     <= bus_we_d;
      bus_be_q     <= bus_be_d;
      bus_wdata_q  <= bus_wdata_d;
      f3_q         <= f3_d;
      off_q        <= off_d;
      rdata_q      <= rdata_d;
      done_fault_q <= done_fault_d;
    end
  end

  // Idle-cycle decode is combinational, so force it low while reset is held.
  assign stall     = stall_c & rst_n;
  assign fault     = (fault_c | done_fault_q) & rst_n;
  assign bus_req   = (state_q == REQ);
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_be    = bus_be_q;
  assign bus_wdata = bus_wdata_q;
  assign rdata     = rdata_q;

endmodule

// File: tb/tb_lsu_bus_bridge.sv
// Self-checking bench for lsu_bus_bridge against a behavioural access model.
module tb_lsu_bus_bridge;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_read = 1'b0, mem_write = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] addr = '0, wdata = '0;
  logic [31:0] rdata;
  logic        stall, fault, bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack = 1'b0, bus_err = 1'b0;
  logic [31:0] bus_rdata = '0;

  int checks = 0;
  int errors = 0;
  logic [31:0] model_rdata = '0;

  always #5 clk = ~clk;

  lsu_bus_bridge #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
    .funct3(funct3), .addr(addr), .wdata(wdata), .rdata(rdata),
    .stall(stall), .fault(fault), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_err(bus_err), .bus_rdata(bus_rdata)
  );

  // ---------------- reference model ----------------
  function automatic int m_bytes(input logic [2:0] f3);
    if (f3[1:0] == 2'd0) return 1;
    if (f3[1:0] == 2'd1) return 2;
    return 4;
  endfunction

  function automatic bit m_legal(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] a);
    int f = int'(f3);
    if (rd && wr) return 0;
    if (rd && !(f == 0 || f == 1 || f == 2 || f == 4 || f == 5)) return 0;
    if (wr && !(f == 0 || f == 1 || f == 2)) return 0;
    return (a % m_bytes(f3)) == 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
    int off = int'(a % 4);
    if (m_bytes(f3) == 1) return 4'(1 << off);
    if (m_bytes(f3) == 2) return 4'(3 << off);
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] w);
    if (m_bytes(f3) == 1) return (w % 256) * 32'h0101_0101;
    if (m_bytes(f3) == 2) return (w % 65536) * 32'h0001_0001;
    return w;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] word);
    logic [31:0] s = word >> (8 * (a % 4));
    logic [31:0] b = s % 256;
    logic [31:0] h = s % 65536;
    case (int'(f3))
      0:       return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      1:       return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      4:       return b;
      5:       return h;
      default: return word;
    endcase
  endfunction

  // ---------------- core/bus driver (no checking) ----------------
  task automatic run_access(
    input  logic rd, input logic wr, input logic [2:0] f3,
    input  logic [31:0] a, input logic [31:0] wd, input logic [31:0] rword,
    input  int waits, input logic err, input logic noack, input logic noise,
    output int n_stall, output int n_req, output int n_fault,
    output logic [3:0] o_be, output logic [31:0] o_addr, output logic [31:0] o_wdata,
    output logic o_we, output logic [31:0] o_rdata, output bit finished);
    n_stall = 0; n_req = 0; n_fault = 0; finished = 0;
    o_be = '0; o_addr = '0; o_wdata = '0; o_we = 1'b0; o_rdata = '0;
    mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = wd;
    bus_ack = 1'b0; bus_err = 1'b0;
    for (int c = 0; c < 100; c++) begin
      #1;
      if (stall) n_stall++;
      if (fault) n_fault++;
      if (!stall) o_rdata = rdata;
      if (bus_req) begin
        n_req++;
        o_be = bus_be; o_addr = bus_addr; o_wdata = bus_wdata; o_we = bus_we;
        if (!noack && n_req == waits + 1) begin
          bus_ack = 1'b1; bus_err = err; bus_rdata = rword;
        end else begin
          bus_ack = 1'b0; bus_err = noise ? 1'($urandom) : 1'b0; bus_rdata = $urandom;
        end
      end else begin
        bus_ack = noise ? 1'($urandom) : 1'b0;
        bus_err = noise ? 1'($urandom) : 1'b0;
        bus_rdata = $urandom;
      end
      if (!stall) finished = 1;
      @(negedge clk);
      if (finished) break;
    end
    mem_read = 1'b0; mem_write = 1'b0; bus_ack = 1'b0; bus_err = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    mem_read = 1'b1; funct3 = 3'b010; addr = 32'h0;
    #1;
    checks++;
    if ({stall, fault, bus_req, bus_we} !== 4'b0000) begin
      errors++; $display("FAIL reset_ctrl: got %b want 0000", {stall, fault, bus_req, bus_we});
    end
    checks++;
    if ({rdata, bus_addr, bus_wdata, bus_be} !== '0) begin
      errors++; $display("FAIL reset_data: rdata=%h addr=%h wdata=%h be=%b want 0", rdata, bus_addr, bus_wdata, bus_be);
    end
    mem_read = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    $display("txn reset: rdata=%h stall=%b", rdata, stall);
  endtask

  task automatic test_lw_basic();
    int ns, nr, nf; logic [3:0] be; logic [31:0] ba, bw, rd; logic we; bit fin;
    run_access(1, 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0, 0, 0, ns, nr, nf, be, ba, bw, we, rd, fin);
    model_rdata = 32'hDEADBEEF;
    $display("txn LW 0x100: stall=%0d req=%0d fault=%0d be=%b rdata=%h", ns, nr, nf, be, rd);
    checks++; if (!fin || ns != 2) begin errors++; $display("FAIL lw_stall: got %0d want 2", ns); end
    checks++; if (be !== 4'b1111 || ba !== 32'h100 || we !== 1'b0) begin
      errors++; $display("FAIL lw_bus: be=%b addr=%h we=%b want 1111 00000100 0", be, ba, we); end
    checks++; if (rd !== 32'hDEADBEEF || nf != 0) begin
      errors++; $display("FAIL lw_rdata: rdata=%h fault=%0d want deadbeef 0", rd, nf); end
  endtask

  task automatic test_lb_sign();
    int ns, nr, nf; logic [3:0] be; logic [31:0] ba, bw, rd; logic we; bit fin;
    run_access(1, 0, 3'b000, 32'h103, 32'h0, 32'h80FF_0000, 1, 0, 0, 0, ns, nr, nf, be, ba, bw, we, rd, fin);
    $display("txn LB 0x103: be=%b rdata=%h", be, rd);
    checks++; if (rd !== 32'hFFFF_FF80 || be !== 4'b1000) begin
      errors++; $display("FAIL lb_sext: rdata=%h be=%b want ffffff80 1000", rd, be); end
    run_access(1, 0, 3'b100, 32'h103, 32'h0, 32'h80FF_0000, 0, 0, 0, 0, ns, nr, nf, be, ba, bw, we, rd, fin);
    model_rdata = 32'h0000_0080;
    $display("txn LBU 0x103: rdata=%h", rd);
    checks++; if (rd !== 32'h0000_0080) begin
      errors++; $display("FAIL lbu_zext: rdata=%h want 00000080", rd); end
  endtask

  task automatic test_sh_waits();
    int ns, nr, nf; logic [3:0] be; logic [31:0] ba, bw, rd; logic we; bit fin;
    run_access(0, 1, 3'b001, 32'h202, 32'h1234ABCD, 32'h5555_5555, 3, 0, 0, 0, ns, nr, nf, be, ba, bw, we, rd, fin);
    $display("txn SH 0x202: stall=%0d be=%b addr=%h wdata=%h rdata=%h", ns, be, ba, bw, rd);
    checks++; if (be !== 4'b1100 || bw !== 32'hABCDABCD || ba !== 32'h200 || we !== 1'b1) begin
      errors++; $display("FAIL sh_bus: be=%b wdata=%h addr=%h we=%b want 1100 abcdabcd 00000200 1", be, bw, ba, we); end
    checks++; if (ns != 5 || nr != 4) begin errors++; $display("FAIL sh_stall: stall=%0d req=%0d want 5 4", ns, nr); end
    checks++; if (rd !== model_rdata) begin errors++; $display("FAIL sh_rdata_keep: got %h want %h", rd, model_rdata); end
  endtask

  task automatic test_misaligned();
    int ns, nr, nf; logic [3:0] be; logic [31:0] ba, bw, rd; logic we; bit fin;
    run_access(1, 0, 3'b010, 32'h101, 32'h0, 32'h0, 0, 0, 0, 1, ns, nr, nf, be, ba, bw, we, rd, fin);
    $display("txn LW 0x101: stall=%0d req=%0d fault=%0d rdata=%h", ns, nr, nf, rd);
    checks++; if (nf != 1 || ns != 0 || nr != 0) begin
      errors++; $display("FAIL misalign: fault=%0d stall=%0d req=%0d want 1 0 0", nf, ns, nr); end
    checks++; if (rd !== model_rdata) begin errors++; $display("FAIL misalign_rdata: got %h want %h", rd, model_rdata); end
    #1;
    checks++; if (fault !== 1'b0 || bus_req !== 1'b0) begin
      errors++; $display("FAIL misalign_after: fault=%b req=%b want 0 0", fault, bus_req); end
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int ns, nr, nf; logic [3:0] be; logic [31:0] ba, bw, rd; logic we; bit fin;
    run_access(1, 0, 3'b001, 32'h40, 32'h0, 32'h0, 0, 0, 1, 1, ns, nr, nf, be, ba, bw, we, rd, fin);
    $display("txn LH timeout: stall=%0d req=%0d fault=%0d rdata=%h", ns, nr, nf, rd);
    checks++; if (!fin || nr != 16 || ns != 17) begin
      errors++; $display("FAIL timeout_len: req=%0d stall=%0d want 16 17", nr, ns); end
    checks++; if (nf != 1 || rd !== model_rdata) begin
      errors++; $display("FAIL timeout_fault: fault=%0d rdata=%h want 1 %h", nf, rd, model_rdata); end
    #1;
    checks++; if (bus_req !== 1'b0 || stall !== 1'b0) begin
      errors++; $display("FAIL timeout_idle: req=%b stall=%b want 0 0", bus_req, stall); end
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    int ns, nr, nf, seen; logic [3:0] be; logic [31:0] ba, bw, rd, wv; logic we; bit fin;
    mem_read = 1'b1; funct3 = 3'b010; addr = 32'h300; seen = 0;
    for (int c = 0; c < 40 && seen < 3; c++) begin
      @(negedge clk); #1;
      if (bus_req) seen++;
    end
    checks++; if (seen != 3) begin errors++; $display("FAIL arst_setup: req cycles %0d want 3", seen); end
    #2 rst_n = 1'b0;
    #1;
    model_rdata = '0;
    $display("txn reset-in-REQ: req=%b stall=%b fault=%b rdata=%h", bus_req, stall, fault, rdata);
    checks++; if (bus_req !== 1'b0 || stall !== 1'b0 || fault !== 1'b0 || rdata !== 32'h0) begin
      errors++; $display("FAIL arst_drop: req=%b stall=%b fault=%b rdata=%h want 0 0 0 0", bus_req, stall, fault, rdata); end
    mem_read = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    wv = $urandom;
    run_access(0, 1, 3'b010, 32'h304, wv, 32'h0, 1, 0, 0, 0, ns, nr, nf, be, ba, bw, we, rd, fin);
    $display("txn SW after reset: stall=%0d be=%b wdata=%h fault=%0d", ns, be, bw, nf);
    checks++; if (!fin || ns != 3 || nr != 2 || nf != 0) begin
      errors++; $display("FAIL arst_sw_timing: stall=%0d req=%0d fault=%0d want 3 2 0", ns, nr, nf); end
    checks++; if (be !== 4'hF || bw !== wv || ba !== 32'h304) begin
      errors++; $display("FAIL arst_sw_bus: be=%b wdata=%h addr=%h want 1111 %h 00000304", be, bw, ba, wv); end
  endtask

  task automatic test_random();
    int ns, nr, nf, waits, xs, xr, xf; logic [3:0] be; logic [31:0] ba, bw, rd, a, wd, rw;
    logic we, r, w, err, noack; logic [2:0] f3; bit fin, legal;
    for (int t = 0; t < 80; t++) begin
      case ($urandom_range(0, 9))
        0:          begin r = 1; w = 1; end
        1, 2, 3, 4: begin r = 0; w = 1; end
        default:    begin r = 1; w = 0; end
      endcase
      f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) f3 = 3'($urandom_range(0, 2)) | (r ? {$urandom_range(0,1) == 1, 2'b00} : 3'b000);
      a = $urandom; wd = $urandom; rw = $urandom;
      if ($urandom_range(0, 2) != 0) a = a & ~32'((m_bytes(f3)) - 1);
      waits = $urandom_range(0, 5);
      err = ($urandom_range(0, 7) == 0);
      noack = ($urandom_range(0, 24) == 0);
      legal = m_legal(r, w, f3, a);
      run_access(r, w, f3, a, wd, rw, waits, err, noack, 1, ns, nr, nf, be, ba, bw, we, rd, fin);
      xr = legal ? (noack ? 16 : waits + 1) : 0;
      xs = legal ? xr + 1 : 0;
      xf = (!legal || noack || err) ? 1 : 0;
      if (legal && r && !noack && !err) model_rdata = m_load(f3, a, rw);
      $display("txn rnd%0d rd=%b wr=%b f3=%0d addr=%h waits=%0d err=%b noack=%b: stall=%0d req=%0d fault=%0d rdata=%h",
               t, r, w, f3, a, waits, err, noack, ns, nr, nf, rd);
      checks++; if (!fin || ns != xs || nr != xr || nf != xf) begin
        errors++; $display("FAIL rnd%0d_timing: stall=%0d req=%0d fault=%0d want %0d %0d %0d", t, ns, nr, nf, xs, xr, xf); end
      checks++; if (rd !== model_rdata) begin
        errors++; $display("FAIL rnd%0d_rdata: got %h want %h", t, rd, model_rdata); end
      if (legal) begin
        checks++;
        if (be !== m_be(f3, a) || ba !== (a & 32'hFFFF_FFFC) || we !== w ||
            (w && bw !== m_wdata(f3, wd))) begin
          errors++; $display("FAIL rnd%0d_bus: be=%b addr=%h we=%b wdata=%h want %b %h %b %h",
                             t, be, ba, we, bw, m_be(f3, a), a & 32'hFFFF_FFFC, w, m_wdata(f3, wd));
        end
      end
      #1;
      checks++; if (bus_req !== 1'b0 || fault !== 1'b0) begin
        errors++; $display("FAIL rnd%0d_after: req=%b fault=%b want 0 0", t, bus_req, fault); end
      @(negedge clk);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_lw_basic();
    test_lb_sign();
    test_sh_waits();
    test_misaligned();
    test_timeout();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu_bus_bridge.md
Name: lsu_bus_bridge

Overview:
- Load/store unit sitting directly downstream of the single-cycle core's MEM stage.
- Consumes the core's MemRead/MemWrite, ALU-result address and rs2 store data.
- Drives a word-wide request/acknowledge data bus, producing byte enables, lane alignment and load sign/zero extension.
- Returns load data to the write-back mux; asserts stall so the core holds its PC until the access completes.

Parameters:
- TIMEOUT_CYCLES, 16: max cycles in REQ without bus_ack before an aborted access with fault.
- CNT_W, 5: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- mem_read  in  1  core load request (level, held while stall=1).
- mem_write  in  1  core store request (level, held while stall=1).
- funct3  in  3  instruction[14:12]: access size and signedness.
- addr  in  32  byte address (ALU result).
- wdata  in  32  store data (rs2), value in low bits.
- rdata  out  32  extended load result, registered.
- stall  out  1  core must hold PC and register-file writes.
- fault  out  1  one-cycle pulse: misaligned access, illegal funct3/request, bus error or timeout.
- bus_req  out  1  bus request, held until ack or timeout.
- bus_we  out  1  1 = write.
- bus_addr  out  32  word address, {addr[31:2],2'b00}.
- bus_be  out  4  byte enables.
- bus_wdata  out  32  lane-replicated store data.
- bus_ack  in  1  one-cycle completion strobe.
- bus_err  in  1  error qualifier, sampled only with bus_ack.
- bus_rdata  in  32  read word, valid with bus_ack.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; all outputs 0; timeout counter 0. A reset in REQ drops bus_req immediately, with no completion.
- States: IDLE, REQ, DONE.
- Legal funct3 for loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- Legal funct3 for stores: 000 SB, 001 SH, 010 SW.
- Alignment: halfword requires addr[0]=0; word requires addr[1:0]=00.
- IDLE, no request: stall=0, nothing happens.
- IDLE, request legal and aligned:
  - stall=1 combinationally in the same cycle.
  - Latch bus_addr, bus_we, bus_be, bus_wdata, funct3 and addr[1:0].
  - Next state REQ.
- IDLE, request illegal:
  - Covers misaligned address, illegal funct3, or mem_read and mem_write both high.
  - fault=1 for that cycle, stall=0, no bus access, rdata unchanged; stay IDLE.
- REQ:
  - bus_req=1, stall=1, counter increments each cycle.
  - On bus_ack with bus_err=0: a load captures extended data into rdata; a store commits. Next state DONE.
  - On bus_ack with bus_err=1: fault pulses in DONE; rdata unchanged.
  - Timeout: counter reaches TIMEOUT_CYCLES with no ack. Drop bus_req, next state DONE with fault pulse.
  - bus_req deasserts in the cycle after ack.
- DONE:
  - stall=0 and rdata valid, so the core writes back and advances PC at this edge.
  - Always returns to IDLE. The core's still-asserted request is not re-issued in DONE.
- Latency: a 0-wait-state bus (ack in the first REQ cycle) gives 3 cycles per load/store (IDLE, REQ, DONE). Each wait state adds 1 cycle.
- Byte enables and data lanes:
  - SB: be = 0001 << addr[1:0]; wdata byte replicated on all 4 lanes.
  - SH: be = 0011 << addr[1:0]; halfword replicated on both halves.
  - SW: be = 1111.
- Loads: select byte/half by addr[1:0], then sign-extend (LB, LH) or zero-extend (LBU, LHU).
- rdata holds the last successful load value; stores do not modify it.
- bus_ack outside REQ is ignored. bus_err without bus_ack is ignored.

Decomposition:
- Package lsu_pkg:
  - state enum (IDLE, REQ, DONE).
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - be base masks.
- One combinational sub-module, lsu_align:
  - store side: byte-enable and lane-replication.
  - load side: lane-select and sign/zero-extension.
- lsu_align is shared by both paths and unit-tested standalone. The FSM and counter stay in lsu_bus_bridge.

Test Plan:
- LW addr=0x100, bus_rdata=0xDEADBEEF, ack in first REQ cycle -> stall high 2 cycles, bus_be=1111, rdata=0xDEADBEEF in DONE, fault=0.
- LB addr=0x103, bus_rdata=0x80FF_0000 -> rdata=0xFFFFFF80. Same stimulus with LBU -> rdata=0x00000080.
- SH addr=0x202, wdata=0x1234ABCD, ack after 3 wait states -> bus_be=1100, bus_wdata=0xABCDABCD, bus_addr=0x200, stall high 5 cycles.
- LW addr=0x101 -> fault pulse 1 cycle, stall=0, bus_req never asserted, rdata unchanged.
- Load with bus_ack never asserted, TIMEOUT_CYCLES=16 -> bus_req high exactly 16 cycles, then fault pulse in DONE, back to IDLE.
- rst_n pulled low during REQ wait -> bus_req and stall drop asynchronously, state IDLE. After release a new SW completes normally.
